// File: rtl/skid_pipeline.sv
// Chain of DEPTH full-throughput skid-buffer stages on a valid/ready stream,
// with a registered occupancy count and a synchronous flush.
module skid_pipeline #(
    parameter  int unsigned DATA_WIDTH = 7,
    parameter  int unsigned DEPTH      = 2,
    localparam int unsigned CNT_W      = $clog2(2 * DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] up_bus,
    input  logic                  up_val,
    output logic                  up_rdy,
    output logic [DATA_WIDTH-1:0] dn_bus,
    output logic                  dn_val,
    input  logic                  dn_rdy,
    output logic [CNT_W-1:0]      count
);

    logic [DEPTH-1:0]      main_val;
    logic [DEPTH-1:0]      stg_rdy;
    logic [DEPTH-1:0]      in_val_c;
    logic [DEPTH-1:0]      out_rdy_c;
    logic [DATA_WIDTH-1:0] main_data [DEPTH];
    logic [DATA_WIDTH-1:0] in_data_c [DEPTH];
    logic                  in_fire_c;
    logic                  out_fire_c;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            logic                  mv;
            logic                  sv;
            logic                  rd;
            logic [DATA_WIDTH-1:0] md;
            logic [DATA_WIDTH-1:0] sd;
            logic                  acc_c;

            // Stage k is fed by stage k-1 (or the producer) and drained by k+1 (or the consumer).
            if (k == 0) begin : g_head
                assign in_val_c[k]  = up_val;
                assign in_data_c[k] = up_bus;
            end else begin : g_mid
                assign in_val_c[k]  = main_val[k-1];
                assign in_data_c[k] = main_data[k-1];
            end
            if (k == DEPTH - 1) begin : g_tail
                assign out_rdy_c[k] = dn_rdy;
            end else begin : g_next
                assign out_rdy_c[k] = stg_rdy[k+1];
            end

            assign acc_c        = in_val_c[k] & rd;
            assign main_val[k]  = mv;
            assign main_data[k] = md;
            assign stg_rdy[k]   = rd;

            // Ready is kept as a flop equal to !skid valid so it never sees dn_rdy combinationally.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mv <= 1'b0;
                    sv <= 1'b0;
                    rd <= 1'b1;
                    md <= '0;
                    sd <= '0;
                end else if (flush) begin
                    mv <= 1'b0;
                    sv <= 1'b0;
                    rd <= 1'b1;
                end else if (!mv || out_rdy_c[k]) begin
                    if (sv) begin
                        md <= sd;
                        mv <= 1'b1;
                    end else if (acc_c) begin
                        md <= in_data_c[k];
                        mv <= 1'b1;
                    end else begin
                        mv <= 1'b0;
                    end
                    sv <= 1'b0;
                    rd <= 1'b1;
                end else if (acc_c) begin
                    sd <= in_data_c[k];
                    sv <= 1'b1;
                    rd <= 1'b0;
                end
            end
        end
    endgenerate

    assign up_rdy     = stg_rdy[0];
    assign dn_val     = main_val[DEPTH-1];
    assign dn_bus     = main_data[DEPTH-1];
    assign in_fire_c  = up_val & stg_rdy[0];
    assign out_fire_c = main_val[DEPTH-1] & dn_rdy;

    // Occupancy tracks accepted minus delivered words; bounded by 2*DEPTH by construction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(in_fire_c) - CNT_W'(out_fire_c);
        end
    end

endmodule

// File: tb/tb_skid_pipeline.sv
// Scoreboard bench for skid_pipeline: default instance plus DEPTH=1/W=32 and DEPTH=4/W=7.
module tb_skid_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        flush0, up_val0, up_rdy0, dn_val0, dn_rdy0;
    logic [6:0]  up_bus0, dn_bus0;
    logic [2:0]  count0;

    logic        flush1, up_val1, up_rdy1, dn_val1, dn_rdy1;
    logic [31:0] up_bus1, dn_bus1;
    logic [1:0]  count1;

    logic        flush2, up_val2, up_rdy2, dn_val2, dn_rdy2;
    logic [6:0]  up_bus2, dn_bus2;
    logic [3:0]  count2;

    skid_pipeline u0 (
        .clk(clk), .rst(rst), .flush(flush0), .up_bus(up_bus0), .up_val(up_val0),
        .up_rdy(up_rdy0), .dn_bus(dn_bus0), .dn_val(dn_val0), .dn_rdy(dn_rdy0), .count(count0)
    );
    skid_pipeline #(.DATA_WIDTH(32), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush1), .up_bus(up_bus1), .up_val(up_val1),
        .up_rdy(up_rdy1), .dn_bus(dn_bus1), .dn_val(dn_val1), .dn_rdy(dn_rdy1), .count(count1)
    );
    skid_pipeline #(.DATA_WIDTH(7), .DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .flush(flush2), .up_bus(up_bus2), .up_val(up_val2),
        .up_rdy(up_rdy2), .dn_bus(dn_bus2), .dn_val(dn_val2), .dn_rdy(dn_rdy2), .count(count2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0]  q0 [$];
    logic [31:0] q1 [$];
    logic [6:0]  q2 [$];
    int model_cnt0 = 0;
    int delivered0 = 0;

    // Scoreboard for u0: pop on delivery, drop queue on flush, push on accept, model occupancy.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            model_cnt0 = 0;
        end else begin
            check("count0", 32'(count0), 32'(model_cnt0));
            if (count0 > 3'd4) check("count0 bound", 32'(count0), 32'd4);
            if (dn_val0 && dn_rdy0) begin
                if (q0.size() == 0) check("dn0 unexpected word", 32'(dn_bus0), 32'hFFFF_FFFF);
                else check("dn_bus0", 32'(dn_bus0), 32'(q0.pop_front()));
                delivered0++;
            end
            if (flush0) begin
                q0.delete();
                model_cnt0 = 0;
            end else begin
                if (up_val0 && up_rdy0) q0.push_back(up_bus0);
                model_cnt0 = model_cnt0 + int'(up_val0 && up_rdy0) - int'(dn_val0 && dn_rdy0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            if (dn_val1 && dn_rdy1) begin
                if (q1.size() == 0) check("dn1 unexpected word", dn_bus1, 32'hDEAD_0001);
                else check("dn_bus1", dn_bus1, q1.pop_front());
            end
            if (up_val1 && up_rdy1) q1.push_back(up_bus1);
            if (dn_val2 && dn_rdy2) begin
                if (q2.size() == 0) check("dn2 unexpected word", 32'(dn_bus2), 32'hDEAD_0002);
                else check("dn_bus2", 32'(dn_bus2), 32'(q2.pop_front()));
            end
            if (up_val2 && up_rdy2) q2.push_back(up_bus2);
        end
    end

    initial begin
        int acc;
        int fall_cyc;
        int d_before;
        int cyc;
        logic a;

        rst = 1'b1;
        flush0 = 0; up_val0 = 0; dn_rdy0 = 0; up_bus0 = '0;
        flush1 = 0; up_val1 = 0; dn_rdy1 = 0; up_bus1 = '0;
        flush2 = 0; up_val2 = 0; dn_rdy2 = 0; up_bus2 = '0;
        #1;
        check("rst up_rdy0", 32'(up_rdy0), 32'd1);
        check("rst dn_val0", 32'(dn_val0), 32'd0);
        check("rst dn_bus0", 32'(dn_bus0), 32'd0);
        check("rst count0", 32'(count0), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Streaming 1..20 with dn_rdy=1: latency 2, no gaps, count steady at 2
        dn_rdy0 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            up_val0 = 1'b1;
            up_bus0 = 7'(i);
            tick();
            check("stream up_rdy0", 32'(up_rdy0), 32'd1);
            if (i == 1) begin
                check("stream latency early", 32'(dn_val0), 32'd0);
            end else begin
                check("stream dn_val0", 32'(dn_val0), 32'd1);
                check("stream dn_bus0", 32'(dn_bus0), 32'(i - 1));
                check("stream count0", 32'(count0), 32'd2);
            end
        end
        up_val0 = 1'b0;
        tick();
        check("stream last word", 32'(dn_bus0), 32'd20);
        tick();
        check("stream drained val", 32'(dn_val0), 32'd0);
        check("stream drained count", 32'(count0), 32'd0);

        // Fill with dn_rdy=0, then drain
        dn_rdy0 = 1'b0;
        up_val0 = 1'b1;
        up_bus0 = 7'h10;
        acc = 0;
        fall_cyc = -1;
        d_before = delivered0;
        for (int c = 1; c <= 10; c++) begin
            a = up_val0 & up_rdy0;
            tick();
            if (a) begin
                acc++;
                up_bus0 = up_bus0 + 7'd1;
            end
            if (!up_rdy0 && fall_cyc < 0) fall_cyc = c;
        end
        check("fill accepted", 32'(acc), 32'd4);
        check("fill up_rdy fall cycle", 32'(fall_cyc), 32'd4);
        check("fill up_rdy0", 32'(up_rdy0), 32'd0);
        check("fill count0", 32'(count0), 32'd4);
        check("fill dn_bus0 held", 32'(dn_bus0), 32'h10);
        up_val0 = 1'b0;
        dn_rdy0 = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check("drain delivered", 32'(delivered0 - d_before), 32'd4);
        check("drain up_rdy0", 32'(up_rdy0), 32'd1);
        check("drain count0", 32'(count0), 32'd0);

        // Flush with count=3 and 0x55 offered
        dn_rdy0 = 1'b0;
        up_val0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_bus0 = 7'(8'h21 + i);
            tick();
        end
        check("preflush count0", 32'(count0), 32'd3);
        up_bus0 = 7'h55;
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        up_val0 = 1'b0;
        check("flush count0", 32'(count0), 32'd0);
        check("flush dn_val0", 32'(dn_val0), 32'd0);
        check("flush up_rdy0", 32'(up_rdy0), 32'd1);
        dn_rdy0 = 1'b1;
        up_val0 = 1'b1;
        up_bus0 = 7'h66;
        tick();
        up_val0 = 1'b0;
        check("post-flush early", 32'(dn_val0), 32'd0);
        tick();
        check("post-flush dn_val0", 32'(dn_val0), 32'd1);
        check("post-flush dn_bus0", 32'(dn_bus0), 32'h66);
        tick();

        // Random up_val/dn_rdy, 1000 words
        acc = 0;
        d_before = delivered0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            up_val0 = 1'($urandom_range(0, 1));
            dn_rdy0 = 1'($urandom_range(0, 1));
            if (up_val0 && up_rdy0) acc++;
            tick();
            if (!(up_val0 && !up_rdy0)) up_bus0 = 7'($urandom_range(0, 127));
            cyc++;
        end
        check("random accepted", 32'(acc), 32'd1000);
        up_val0 = 1'b0;
        dn_rdy0 = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("random delivered", 32'(delivered0 - d_before), 32'd1000);
        check("random scoreboard empty", 32'(q0.size()), 32'd0);

        // Asynchronous reset mid-stream with count=3
        dn_rdy0 = 1'b0;
        up_val0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_bus0 = 7'(8'h31 + i);
            tick();
        end
        up_val0 = 1'b0;
        check("prerst count0", 32'(count0), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("async rst dn_val0", 32'(dn_val0), 32'd0);
        check("async rst dn_bus0", 32'(dn_bus0), 32'd0);
        check("async rst up_rdy0", 32'(up_rdy0), 32'd1);
        check("async rst count0", 32'(count0), 32'd0);
        tick();
        rst = 1'b0;
        dn_rdy0 = 1'b1;
        up_val0 = 1'b1;
        up_bus0 = 7'h41;
        tick();
        up_val0 = 1'b0;
        tick();
        check("after rst dn_val0", 32'(dn_val0), 32'd1);
        check("after rst dn_bus0", 32'(dn_bus0), 32'h41);
        tick(); tick();

        // DEPTH=1, 32-bit: capacity 2, latency 1, full width
        dn_rdy1 = 1'b0;
        up_val1 = 1'b1;
        up_bus1 = 32'hFFFF_FFFF;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            a = up_val1 & up_rdy1;
            tick();
            if (a) begin
                acc++;
                up_bus1 = 32'(acc);
            end
        end
        check("d1 capacity", 32'(acc), 32'd2);
        check("d1 count", 32'(count1), 32'd2);
        check("d1 up_rdy", 32'(up_rdy1), 32'd0);
        check("d1 head word", dn_bus1, 32'hFFFF_FFFF);
        up_val1 = 1'b0;
        dn_rdy1 = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        check("d1 drained", 32'(count1), 32'd0);
        up_val1 = 1'b1;
        up_bus1 = 32'hA5A5_5A5A;
        tick();
        up_val1 = 1'b0;
        check("d1 latency val", 32'(dn_val1), 32'd1);
        check("d1 latency bus", dn_bus1, 32'hA5A5_5A5A);
        tick(); tick();

        // DEPTH=4, 7-bit: capacity 8, latency 4, full width
        dn_rdy2 = 1'b0;
        up_val2 = 1'b1;
        up_bus2 = 7'h7F;
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            a = up_val2 & up_rdy2;
            tick();
            if (a) begin
                acc++;
                up_bus2 = 7'(acc);
            end
        end
        check("d4 capacity", 32'(acc), 32'd8);
        check("d4 count", 32'(count2), 32'd8);
        check("d4 up_rdy", 32'(up_rdy2), 32'd0);
        check("d4 head word", 32'(dn_bus2), 32'h7F);
        up_val2 = 1'b0;
        dn_rdy2 = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        check("d4 drained", 32'(count2), 32'd0);
        up_val2 = 1'b1;
        up_bus2 = 7'h7F;
        tick();
        up_val2 = 1'b0;
        tick(); tick();
        check("d4 latency early", 32'(dn_val2), 32'd0);
        tick();
        check("d4 latency val", 32'(dn_val2), 32'd1);
        check("d4 latency bus", 32'(dn_bus2), 32'h7F);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/skid_pipeline.md
# skid_pipeline

Parametrised chain of DEPTH full-throughput skid-buffer stages on a valid/ready stream, with a registered occupancy count and a synchronous flush. It generalises the fixed two-stage skid chain into a single configurable block. It is inserted between a producer and a consumer wherever timing needs registered `up_rdy`, `dn_val` and `dn_bus` across several pipeline cuts. The occupancy and flush are used by the control logic for drain detection and error recovery.

## Interface
- `DATA_WIDTH`, default 7: payload width in bits, ≥1.
- `DEPTH`, default 2: number of skid stages, ≥1; capacity is 2*DEPTH words.
- `CNT_W`, default `$clog2(2*DEPTH+1)`: occupancy width (localparam, not overridable).
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `flush`, in, 1: synchronous discard of all held words.
- `up_bus`, in, DATA_WIDTH: upstream payload.
- `up_val`, in, 1: upstream valid.
- `up_rdy`, out, 1: upstream ready; registered.
- `dn_bus`, out, DATA_WIDTH: downstream payload; registered.
- `dn_val`, out, 1: downstream valid; registered.
- `dn_rdy`, in, 1: downstream ready.
- `count`, out, CNT_W: number of words currently held; registered.

## Operation
- Transfers:
  - Upstream transfer (in_fire) = `up_val & up_rdy`.
  - Downstream transfer (out_fire) = `dn_val & dn_rdy`.
  - Stage k's downstream side feeds stage k+1's upstream side; stage 0 faces `up_*`, stage DEPTH-1 faces `dn_*`.
- Per-stage state: `main_val`/`main_data` (drives the stage output) and `skid_val`/`skid_data`. Stage ready = `!skid_val`, as a register.
- Per-stage next-state rules:
  - If stage output is empty or its downstream is ready:
    - `main` loads `skid` when `skid_val`; otherwise it loads the input on an accept; otherwise `main_val`←0.
    - `skid_val`←0.
  - Else (main held, stalled): an accept loads `skid` (`skid_val`←1); `main` holds.
  - Data registers load only on the transfers above; they never change while their valid flag is held with the downstream not ready.
- Ordering: strict FIFO; no word is dropped or duplicated except on flush.
- Occupancy: `count` ← `count + in_fire - out_fire`, saturating is not required. It never exceeds 2*DEPTH by construction; an assertion in the bench checks this.
- Flush (`flush`=1 at an edge):
  - All `main_val`/`skid_val`←0; every stage ready←1; `count`←0.
  - A word offered with in_fire in the flush cycle is discarded.
  - A word with out_fire in the flush cycle counts as delivered to the consumer.
  - Data registers are not cleared.
- Reset (`rst`=1, any time, including mid-transfer):
  - All valid flags 0, all stage readies 1, all data registers 0, `count`=0.
  - Outputs `up_rdy`=1, `dn_val`=0, `dn_bus`=0, `count`=0, asynchronously.
  - Operation resumes on the first edge after `rst` deasserts.

## Timing
- Latency: a word accepted at edge t appears on `dn_bus` with `dn_val`=1 after edge t+DEPTH when the pipe is empty and unstalled.
- Throughput: one word per cycle sustained with `dn_rdy`=1; no bubbles.
- Backpressure:
  - With `dn_rdy` held 0 from an empty state and `up_val`=1, exactly 2*DEPTH words are accepted.
  - `up_rdy` falls the cycle after the last accept.
- Restart: `up_rdy` rises one cycle after stage 0's skid drains. It never depends combinationally on `dn_rdy`.
- No combinational paths exist from inputs to outputs.
- `count` reflects transfers of the previous edge, i.e. it lags in_fire/out_fire by one cycle.
- Simultaneous events:
  - in_fire and out_fire in the same cycle leaves `count` unchanged.
  - `flush` overrides both; `rst` overrides `flush`.

## Test plan
- Reset mid-stream: assert `rst` asynchronously with count=3 -> immediately `dn_val`=0, `dn_bus`=0, `up_rdy`=1, `count`=0; the next stream after release starts clean.
- Streaming, DEPTH=2, `dn_rdy`=1: push 1..20 on consecutive cycles -> the first `dn_val` arrives 2 edges after the first accept; 1..20 exit in order with no gaps; `count` is steady at 2.
- Fill/drain, DEPTH=2, `dn_rdy`=0: push 0x10,0x11,… -> 4 words are accepted, `up_rdy`=0, `count`=4, `dn_bus`=0x10 held stable; then `dn_rdy`=1 -> 0x10..0x13 delivered, `up_rdy` returns to 1, `count` reaches 0.
- Random `up_val`/`dn_rdy` (50% each), 1000 words -> the scoreboard matches exactly; `count` equals accepted minus delivered every cycle and stays ≤4.
- Flush with count=3 and `up_val`=1 carrying 0x55 -> next cycle `count`=0, `dn_val`=0, `up_rdy`=1; 0x55 is never delivered; the next word pushed (0x66) is delivered first, after 2 edges.
- Instances with DEPTH=1/DATA_WIDTH=32 and DEPTH=4/DATA_WIDTH=7:
  - Fill with `dn_rdy`=0 -> capacity is 2 and 8 respectively.
  - Latency is 1 and 4 respectively.
  - Full-width values 0xFFFFFFFF/0x7F pass intact.
